// File: rtl/register_unit_sb.sv
// RISC-V integer register file with write-to-read bypass, pending-write
// scoreboard and a sequential clear engine.
module register_unit_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [XLEN-1:0]   RURs1,
   output logic [XLEN-1:0]   RURs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [XLEN-1:0]   DataWr,
   input  logic              RUWr,
   input  logic              issue_vld,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              busy_rs1,
   output logic              busy_rs2,
   input  logic              clr_req,
   output logic              clr_busy
);

   typedef enum logic {S_IDLE, S_CLEAR} state_e;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [XLEN-1:0]     regs_q [NREGS];
   logic [XLEN-1:0]     regs_d [NREGS];
   logic [NREGS-1:0]    sb_q, sb_d;
   logic                wr_en, iss_en;
   logic                fwd1, fwd2;

   assign wr_en  = RUWr && (rd != '0) && (state_q == S_IDLE);
   assign iss_en = issue_vld && (issue_rd != '0);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      regs_d  = regs_q;
      sb_d    = sb_q;
      unique case (state_q)
         S_IDLE: begin
            if (wr_en) regs_d[rd] = DataWr;
            if (clr_req) begin
               state_d = S_CLEAR;
               ptr_d   = ONE;
               sb_d    = '0;
            end else begin
               // issue is applied after writeback so a collision leaves it set
               if (wr_en) sb_d[rd] = 1'b0;
               if (iss_en) sb_d[issue_rd] = 1'b1;
            end
         end
         S_CLEAR: begin
            regs_d[ptr_q] = '0;
            if (ptr_q == LAST) state_d = S_IDLE;
            else ptr_d = ptr_q + ONE;
         end
         default: state_d = S_IDLE;
      endcase
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= ONE;
         regs_q  <= '{default: '0};
         sb_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         regs_q  <= regs_d;
         sb_q    <= sb_d;
      end
   end

   assign fwd1 = (BYPASS != 0) && wr_en && (rd == rs1);
   assign fwd2 = (BYPASS != 0) && wr_en && (rd == rs2);

   assign RURs1 = (rs1 == '0) ? '0 : (fwd1 ? DataWr : regs_q[rs1]);
   assign RURs2 = (rs2 == '0) ? '0 : (fwd2 ? DataWr : regs_q[rs2]);

   assign busy_rs1 = (rs1 != '0) && sb_q[rs1] &&
                     !(fwd1 && !(issue_vld && issue_rd == rs1));
   assign busy_rs2 = (rs2 != '0) && sb_q[rs2] &&
                     !(fwd2 && !(issue_vld && issue_rd == rs2));

   assign clr_busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_register_unit_sb.sv
// Testbench for register_unit_sb: directed scenarios plus randomized
// traffic compared against a behavioural register-file model.
module tb_register_unit_sb;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int BYPASS = 1;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1, rs2, rd, issue_rd;
   logic [31:0] RURs1, RURs2, DataWr;
   logic        RUWr, issue_vld, clr_req;
   logic        busy_rs1, busy_rs2, clr_busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_reg [NREGS];
   bit          m_sb  [NREGS];
   int          clear_left;

   register_unit_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1(rs1), .rs2(rs2), .RURs1(RURs1), .RURs2(RURs2),
      .rd(rd), .DataWr(DataWr), .RUWr(RUWr),
      .issue_vld(issue_vld), .issue_rd(issue_rd),
      .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_reg[i] = '0;
         m_sb[i]  = 1'b0;
      end
      clear_left = 0;
   endtask

   task automatic idle_inputs();
      rs1 = 0; rs2 = 0; rd = 0; DataWr = 0; RUWr = 0;
      issue_vld = 0; issue_rd = 0; clr_req = 0;
   endtask

   // Advance one clock and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (clear_left > 0) begin
            m_reg[NREGS - clear_left] = '0;
            clear_left--;
         end else begin
            if (RUWr && rd != 0) m_reg[rd] = DataWr;
            if (clr_req) begin
               for (int i = 0; i < NREGS; i++) m_sb[i] = 1'b0;
               clear_left = NREGS - 1;
            end else begin
               if (RUWr && rd != 0) m_sb[rd] = 1'b0;
               if (issue_vld && issue_rd != 0) m_sb[issue_rd] = 1'b1;
            end
         end
      end
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return '0;
      if (BYPASS != 0 && clear_left == 0 && RUWr && rd == a) return DataWr;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (BYPASS != 0 && clear_left == 0 && RUWr && rd == a &&
          !(issue_vld && issue_rd == a)) return 1'b0;
      return m_sb[a];
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      rs1 = 5; rs2 = 31;
      #1;
      checks++;
      if (RURs1 !== 0) begin failures++; $display("FAIL reset_rurs1 got=%h exp=0", RURs1); end
      checks++;
      if (RURs2 !== 0) begin failures++; $display("FAIL reset_rurs2 got=%h exp=0", RURs2); end
      checks++;
      if (busy_rs1 !== 0 || busy_rs2 !== 0) begin
         failures++; $display("FAIL reset_busy got=%b%b exp=00", busy_rs1, busy_rs2);
      end
      checks++;
      if (clr_busy !== 0) begin failures++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_bypass();
      idle_inputs();
      RUWr = 1; rd = 5; DataWr = 1234; rs2 = 5;
      #1;
      checks++;
      if (RURs2 !== (BYPASS != 0 ? 32'd1234 : 32'd0)) begin
         failures++; $display("FAIL bypass_same_cycle got=%0d exp=%0d", RURs2, BYPASS != 0 ? 1234 : 0);
      end
      tick();
      idle_inputs();
      rs1 = 5;
      #1;
      checks++;
      if (RURs1 !== 1234) begin failures++; $display("FAIL write_visible got=%0d exp=1234", RURs1); end
      tick();
   endtask

   task automatic test_x0();
      idle_inputs();
      RUWr = 1; rd = 0; DataWr = 32'hDEADBEEF; rs1 = 0; rs2 = 5;
      #1;
      checks++;
      if (RURs1 !== 0) begin failures++; $display("FAIL x0_same_cycle got=%h exp=0", RURs1); end
      tick();
      RUWr = 0;
      #1;
      checks++;
      if (RURs1 !== 0) begin failures++; $display("FAIL x0_next_cycle got=%h exp=0", RURs1); end
      checks++;
      if (RURs2 !== 1234) begin failures++; $display("FAIL x0_other_reg got=%0d exp=1234", RURs2); end
      tick();
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      issue_vld = 1; issue_rd = 7;
      tick();
      idle_inputs();
      rs1 = 7;
      #1;
      checks++;
      if (busy_rs1 !== 1) begin failures++; $display("FAIL sb_set got=%b exp=1", busy_rs1); end
      RUWr = 1; rd = 7; DataWr = 77;
      #1;
      checks++;
      if (busy_rs1 !== (BYPASS == 0)) begin
         failures++; $display("FAIL sb_fwd_clear got=%b exp=%b", busy_rs1, BYPASS == 0);
      end
      tick();
      RUWr = 0;
      #1;
      checks++;
      if (busy_rs1 !== 0) begin failures++; $display("FAIL sb_cleared got=%b exp=0", busy_rs1); end
      RUWr = 1; rd = 7; DataWr = 88; issue_vld = 1; issue_rd = 7;
      tick();
      idle_inputs();
      rs1 = 7;
      #1;
      checks++;
      if (busy_rs1 !== 1) begin failures++; $display("FAIL sb_set_wins got=%b exp=1", busy_rs1); end
      checks++;
      if (RURs1 !== 88) begin failures++; $display("FAIL sb_collide_data got=%0d exp=88", RURs1); end
   endtask

   task automatic test_clear();
      int cnt;
      idle_inputs();
      for (int i = 1; i < NREGS; i++) begin
         RUWr = 1; rd = 5'(i); DataWr = i;
         tick();
      end
      idle_inputs();
      clr_req = 1;
      tick();
      clr_req = 0;
      cnt = 0;
      while (clr_busy === 1'b1 && cnt < 100) begin
         rs1 = (cnt % 4 == 0) ? 5'd3 : 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         RUWr = 1; rd = 3; DataWr = 999;
         issue_vld = 1; issue_rd = 5'($urandom_range(1, 31));
         #1;
         checks++;
         if (RURs1 !== exp_rd(rs1)) begin
            failures++; $display("FAIL clear_partial rs1=%0d got=%0d exp=%0d", rs1, RURs1, exp_rd(rs1));
         end
         cnt++;
         tick();
      end
      idle_inputs();
      checks++;
      if (cnt != NREGS - 1) begin failures++; $display("FAIL clear_len got=%0d exp=%0d", cnt, NREGS - 1); end
      for (int r = 0; r < NREGS; r++) begin
         rs1 = 5'(r); rs2 = 5'(r);
         #1;
         checks++;
         if (RURs1 !== 0 || busy_rs2 !== 0) begin
            failures++; $display("FAIL clear_zero r=%0d got=%0d busy=%b exp=0", r, RURs1, busy_rs2);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      idle_inputs();
      RUWr = 1; rd = 12; DataWr = 32'h55;
      tick();
      idle_inputs();
      clr_req = 1;
      tick();
      clr_req = 0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (clr_busy !== 0) begin failures++; $display("FAIL rst_mid_clr_busy got=%b exp=0", clr_busy); end
      for (int r = 0; r < NREGS; r++) begin
         rs1 = 5'(r); rs2 = 5'(NREGS - 1 - r);
         #1;
         checks++;
         if (RURs1 !== 0 || RURs2 !== 0) begin
            failures++; $display("FAIL rst_mid_read r=%0d got=%0d/%0d exp=0", r, RURs1, RURs2);
         end
      end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_inputs();
      RUWr = 1; rd = 9; DataWr = 32'hA5A5;
      tick();
      idle_inputs();
      rs1 = 9;
      #1;
      checks++;
      if (RURs1 !== 32'hA5A5) begin failures++; $display("FAIL rst_mid_after got=%h exp=a5a5", RURs1); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rs1 = 5'($urandom); rs2 = 5'($urandom);
         RUWr = ($urandom_range(0, 2) != 0);
         rd = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
         DataWr = $urandom;
         issue_vld = ($urandom_range(0, 1) != 0);
         issue_rd = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
         clr_req = ($urandom_range(0, 79) == 0);
         #1;
         checks++;
         if (RURs1 !== exp_rd(rs1)) begin
            failures++; $display("FAIL rnd_rurs1 n=%0d rs1=%0d got=%h exp=%h", n, rs1, RURs1, exp_rd(rs1));
         end
         checks++;
         if (RURs2 !== exp_rd(rs2)) begin
            failures++; $display("FAIL rnd_rurs2 n=%0d rs2=%0d got=%h exp=%h", n, rs2, RURs2, exp_rd(rs2));
         end
         checks++;
         if (busy_rs1 !== exp_busy(rs1)) begin
            failures++; $display("FAIL rnd_busy1 n=%0d rs1=%0d got=%b exp=%b", n, rs1, busy_rs1, exp_busy(rs1));
         end
         checks++;
         if (busy_rs2 !== exp_busy(rs2)) begin
            failures++; $display("FAIL rnd_busy2 n=%0d rs2=%0d got=%b exp=%b", n, rs2, busy_rs2, exp_busy(rs2));
         end
         checks++;
         if (clr_busy !== (clear_left > 0)) begin
            failures++; $display("FAIL rnd_clr_busy n=%0d got=%b exp=%b", n, clr_busy, clear_left > 0);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_bypass();
      test_x0();
      test_scoreboard();
      test_clear();
      test_reset_mid_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
